hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Hazard detection and stall sequencer for the 5-stage MIPS pipeline. It sits beside the ID stage, directly upstream of the forwarding logic. It decides when the IF/ID and PC must hold and when ID/EX must receive a bubble, so that every operand the forwarding network selects is actually available. It also owns branch/jump flushing of IF/ID and freezes the whole pipeline while memory is busy.

## Interface
Parameters:
- STALL_CW, 2, width of the remaining-stall counter.
- PERF_W, 32, width of the performance counters (only with HAZARD_PERF_EN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_EX_mem_read  in  1  instruction in EX is a load.
- ID_EX_reg_write_en  in  1  instruction in EX writes a register.
- ID_EX_reg_dest  in  5  destination register of the instruction in EX.
- EX_Mem_mem_read  in  1  instruction in MEM is a load.
- EX_Mem_rd  in  5  destination register of the instruction in MEM.
- IF_ID_rs / IF_ID_rt  in  5 each  source registers of the instruction in ID.
- IF_ID_uses_rt  in  1  the ID instruction reads rt (R-type, beq/bne, sw).
- IF_ID_branch  in  1  the ID instruction is beq/bne (compared in ID).
- IF_ID_jump  in  1  the ID instruction is j/jal/jr.
- branch_taken  in  1  ID comparator result.
- mem_busy  in  1  data/instruction memory is not ready; freeze the pipeline.
- pc_write  out  1  PC load enable.
- IF_ID_write  out  1  IF/ID load enable.
- IF_ID_flush  out  1  clear IF/ID to a nop on the next edge.
- ID_EX_flush  out  1  load a bubble (all control zero) into ID/EX.
- stall_active  out  1  high in any cycle in which ID is held.
- stall_cycles, flush_count  out  PERF_W each  performance counters (HAZARD_PERF_EN only).

## Operation
- A register match requires a nonzero register: r0 never produces a hazard. A source matches when `rs==r`, or when `IF_ID_uses_rt && rt==r`.
- Required stall length n is computed combinationally in state RUN, taking the first rule that applies:
  - Branch in ID with a source matching a load in EX: n=2.
  - Load-use (any ID instruction) with a source matching a load in EX: n=1.
  - Branch in ID with a source matching a non-load write in EX (`ID_EX_reg_write_en`): n=1.
  - Branch in ID with a source matching a load in MEM (`EX_Mem_mem_read`, EX_Mem_rd): n=1.
  - Otherwise n=0.
- FSM has two states, RUN and STALL, plus a counter `rem`.
- RUN, n>0:
  - Outputs: pc_write=0, IF_ID_write=0, ID_EX_flush=1, stall_active=1.
  - Next: rem<=n-1. If n-1>0, go to STALL; otherwise stay in RUN.
- STALL: the same stall outputs regardless of the hazard inputs. rem decrements each cycle; when rem reaches 0, go to RUN, and the next RUN cycle re-evaluates the hazards.
- RUN, n=0: pc_write=1, IF_ID_write=1, ID_EX_flush=0. IF_ID_flush=1 if `(IF_ID_branch && branch_taken) || IF_ID_jump`.
- branch_taken and IF_ID_jump are ignored whenever ID is stalled, because the comparator operands are stale.
- mem_busy has the highest priority:
  - Outputs: pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_flush=0.
  - State and rem hold.
  - stall_active reflects the underlying stall condition.
- While rst_n is low, all enables and flushes are 0 and stall_active is 0.

## Timing
- Reset values: state=RUN, rem=0, all perf counters 0. Outputs are as stated above during reset; after release, pc_write=1 and IF_ID_write=1 when no hazard is present.
- Hazard response is combinational (zero latency): the stall is visible in the same cycle the hazard appears in ID.
- A branch dependent on a load in EX holds ID for exactly 2 cycles, and 2 bubbles enter EX. Every other hazard holds ID for 1 cycle and inserts 1 bubble.
- A mem_busy pulse of k cycles lengthens an in-progress stall by exactly k cycles.
- Reset asserted mid-STALL returns to RUN asynchronously with rem=0.
- A stall and a taken branch in the same cycle: the stall wins and no flush occurs. The branch is re-resolved once the stall ends.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles increments in each non-busy cycle with stall_active=1. flush_count increments in each non-busy cycle with IF_ID_flush=1. Both wrap modulo 2^PERF_W and clear only on reset.
- HAZARD_PERF_EN undefined: the counters and their ports are absent; all other behaviour is identical.

## Test plan
- lw $5 in EX, add using rs=$5 in ID → 1 cycle with pc_write=0, IF_ID_write=0, ID_EX_flush=1, then a RUN cycle with pc_write=1.
- lw $5 in EX, beq $5,$6 in ID → 2 consecutive stall cycles (RUN then STALL), state back to RUN on cycle 3; branch_taken=1 during the stall cycles gives IF_ID_flush=0.
- add $0 in EX with a load to $0, ID reads $0 → no stall; beq with branch_taken=1 → IF_ID_flush=1 in the same cycle.
- lw→beq dependence with mem_busy=1 for 3 cycles starting in the STALL cycle → ID held for 5 cycles total; ID_EX_flush=0 during the busy cycles.
- rst_n pulsed low mid-STALL → outputs 0 immediately, state=RUN and rem=0 after release; with no hazard, pc_write=1.
- HAZARD_PERF_EN: run the lw→beq case, then one jump → stall_cycles=2, flush_count=1.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : hazard_stall_ctrl_if
// Brief  : Bundle of hazard inputs seen by the ID-stage stall controller and
//          the pipeline enables/flushes it produces.
//          master : pipeline side (drives hazard info, consumes enables)
//          slave  : stall controller (consumes hazard info, drives enables)
// Rev    : 1.0  initial release
// ============================================================================
interface hazard_stall_ctrl_if;
  // Instruction in EX
  logic       ID_EX_mem_read;
  logic       ID_EX_reg_write_en;
  logic [4:0] ID_EX_reg_dest;
  // Instruction in MEM
  logic       EX_Mem_mem_read;
  logic [4:0] EX_Mem_rd;
  // Instruction in ID
  logic [4:0] IF_ID_rs;
  logic [4:0] IF_ID_rt;
  logic       IF_ID_uses_rt;
  logic       IF_ID_branch;
  logic       IF_ID_jump;
  logic       branch_taken;
  // Memory not ready
  logic       mem_busy;
  // Controls back to the pipeline
  logic       pc_write;
  logic       IF_ID_write;
  logic       IF_ID_flush;
  logic       ID_EX_flush;
  logic       stall_active;

  modport master (
    output ID_EX_mem_read, ID_EX_reg_write_en, ID_EX_reg_dest,
    output EX_Mem_mem_read, EX_Mem_rd,
    output IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, IF_ID_branch, IF_ID_jump,
    output branch_taken, mem_busy,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_active
  );

  modport slave (
    input  ID_EX_mem_read, ID_EX_reg_write_en, ID_EX_reg_dest,
    input  EX_Mem_mem_read, EX_Mem_rd,
    input  IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, IF_ID_branch, IF_ID_jump,
    input  branch_taken, mem_busy,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_active
  );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_stall_ctrl
// Brief  : Hazard detection and stall sequencer for the 5-stage MIPS pipeline.
//          Holds PC and IF/ID and inserts ID/EX bubbles until every operand
//          the forwarding network selects is available; flushes IF/ID on
//          taken branches and jumps; freezes everything while memory is busy.
// Config : HAZARD_PERF_EN - adds stall_cycles / flush_count perf counters.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int unsigned STALL_CW = 2
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned PERF_W   = 32
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]   stall_cycles,
  output logic [PERF_W-1:0]   flush_count
`endif
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t              state_q;
  logic [STALL_CW-1:0] rem_q;

  // r0 is hard-wired zero, so it can never carry a dependence.
  function automatic logic src_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (r != 5'd0) && ((rs == r) || (uses_rt && (rt == r)));
  endfunction

  logic       w_ex_load_hit;
  logic       w_ex_wr_hit;
  logic       w_mem_load_hit;
  logic [1:0] w_need_n;
  logic       w_stall;
  logic       w_if_id_flush;

  assign w_ex_load_hit  = hz.ID_EX_mem_read &&
                          src_match(hz.ID_EX_reg_dest, hz.IF_ID_rs, hz.IF_ID_rt, hz.IF_ID_uses_rt);
  assign w_ex_wr_hit    = hz.ID_EX_reg_write_en &&
                          src_match(hz.ID_EX_reg_dest, hz.IF_ID_rs, hz.IF_ID_rt, hz.IF_ID_uses_rt);
  assign w_mem_load_hit = hz.EX_Mem_mem_read &&
                          src_match(hz.EX_Mem_rd, hz.IF_ID_rs, hz.IF_ID_rt, hz.IF_ID_uses_rt);

  // Required stall length; branches resolve in ID so they need results
  // earlier than ordinary instructions, which forwarding covers from EX.
  always_comb begin
    w_need_n = 2'd0;
    if (hz.IF_ID_branch && w_ex_load_hit)       w_need_n = 2'd2;
    else if (w_ex_load_hit)                     w_need_n = 2'd1;
    else if (hz.IF_ID_branch && w_ex_wr_hit)    w_need_n = 2'd1;
    else if (hz.IF_ID_branch && w_mem_load_hit) w_need_n = 2'd1;
  end

  // ID is held either by a fresh hazard in RUN or by an ongoing STALL.
  assign w_stall = (state_q == STALL) || (w_need_n != 2'd0);

  // Pipeline controls; mem_busy freezes everything, a stall masks the
  // (stale) branch/jump decision so no flush can happen while ID is held.
  always_comb begin
    hz.pc_write     = 1'b0;
    hz.IF_ID_write  = 1'b0;
    w_if_id_flush   = 1'b0;
    hz.ID_EX_flush  = 1'b0;
    hz.stall_active = 1'b0;
    if (rst_n) begin
      hz.stall_active = w_stall;
      if (!hz.mem_busy) begin
        if (w_stall) begin
          hz.ID_EX_flush = 1'b1;
        end else begin
          hz.pc_write    = 1'b1;
          hz.IF_ID_write = 1'b1;
          w_if_id_flush  = (hz.IF_ID_branch && hz.branch_taken) || hz.IF_ID_jump;
        end
      end
    end
  end

  assign hz.IF_ID_flush = w_if_id_flush;

  // Stall sequencer: RUN arms the remaining-cycle counter, STALL counts it down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else if (!hz.mem_busy) begin
      case (state_q)
        RUN: begin
          if (w_need_n != 2'd0) begin
            rem_q   <= STALL_CW'(w_need_n - 2'd1);
            state_q <= (w_need_n > 2'd1) ? STALL : RUN;
          end
        end
        STALL: begin
          if (rem_q <= STALL_CW'(1)) begin
            rem_q   <= '0;
            state_q <= RUN;
          end else begin
            rem_q   <= rem_q - 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
          rem_q   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  // Performance counters; only non-busy cycles count, both wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (!hz.mem_busy) begin
      if (w_stall)       stall_cycles <= stall_cycles + 1'b1;
      if (w_if_id_flush) flush_count  <= flush_count + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
